fpu_ss_fpr_wb_arbiter: RTL
==========================

FPU_SS_FPR_WB_ARBITER -- requirements
Module: fpu_ss_fpr_wb_arbiter

Interface
REQ-001 SHALL have parameter FLEN, default 32: FP register data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4 (legal 1..15): consecutive denied cycles before a requester is promoted.
REQ-003 SHALL have port clk_i, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports mem_valid_i (in, 1), mem_ready_o (out, 1), mem_addr_i (in, 5), mem_data_i (in, FLEN): load-result write request.
REQ-006 SHALL have ports fpu_valid_i (in, 1), fpu_ready_o (out, 1), fpu_addr_i (in, 5), fpu_data_i (in, FLEN): FPnew result write request.
REQ-007 SHALL have ports vec_valid_i (in, 1), vec_ready_o (out, 1), vec_addr_i (in, 5), vec_data_i (in, FLEN): vector-unit write request (see REQ-025).
REQ-008 SHALL have ports fpr_we_o (out, 1), fpr_waddr_o (out, 5), fpr_wdata_o (out, FLEN): registered FP register-file write port.
REQ-009 SHALL have ports sb_clr_o (out, 1), sb_clr_addr_o (out, 5): rd-scoreboard clear pulse, coincident with fpr_we_o.
REQ-010 SHALL have port grant_src_o (out, 2): source of the current write (0 mem, 1 fpu, 2 vec); 0 when fpr_we_o low.

Function
REQ-011 SHALL handshake each source as valid&ready; ready_o is combinational, may depend on valid_i, and is high for at most one source per cycle.
REQ-012 SHALL require sources to hold valid/addr/data stable until ready; arbiter behaviour under a dropped valid is undefined.
REQ-013 SHALL grant by default fixed priority mem > fpu > vec.
REQ-014 SHALL keep a 4-bit starve counter per source: +1 when valid&~ready, saturating at STARVE_LIMIT; cleared on grant or when valid low.
REQ-015 SHALL grant a source whose counter equals STARVE_LIMIT ahead of fixed priority; ties among promoted sources resolve by fixed priority.
REQ-016 SHALL register the granted addr/data into fpr_waddr_o/fpr_wdata_o and pulse fpr_we_o high exactly one cycle after the handshake (latency 1).
REQ-017 SHALL assert sb_clr_o/sb_clr_addr_o identical to fpr_we_o/fpr_waddr_o in the same cycle.
REQ-018 SHALL sustain one write per cycle; back-to-back grants produce consecutive fpr_we_o pulses without bubbles.
REQ-019 SHALL hold fpr_we_o low and leave fpr_waddr_o/fpr_wdata_o unchanged in cycles following no handshake.
REQ-020 SHALL treat same-address requests from multiple sources like any conflict: one granted, others wait; writes land in grant order.
REQ-021 SHALL accept writes to address 0 (FP register f0 is architectural).

Reset
REQ-022 SHALL, while rst_i is high at a clock edge, set fpr_we_o=0, sb_clr_o=0, fpr_waddr_o=0, sb_clr_addr_o=0, fpr_wdata_o=0, grant_src_o=0, all starve counters=0.
REQ-023 SHALL drive all ready_o low while rst_i is high; a write granted the cycle before reset asserts is dropped (fpr_we_o=0 after the edge).
REQ-024 SHALL resume fixed-priority arbitration the first cycle after rst_i deasserts.

Configuration
REQ-025 SHALL, with macro FPU_SS_VEC_WB_EN defined, include the vec_* ports and three-way arbitration as above.
REQ-026 SHALL, without FPU_SS_VEC_WB_EN, omit vec_* ports and the vec counter; arbitration is two-way mem > fpu with the same starvation rule; grant_src_o never equals 2.

Verification
REQ-027 SHALL cover: mem and fpu valid in cycle 0 (mem addr 3, fpu addr 5) -> mem granted c0, fpr_we_o/addr 3 at c1; fpu granted c1, write addr 5 at c2.
REQ-028 SHALL cover: STARVE_LIMIT=4, mem valid continuously with new data each grant, fpu valid from c0 -> fpu denied c0-c3, granted c4, write at c5, counter back to 0.
REQ-029 SHALL cover: all three valid same addr 7, data A/B/C -> writes to 7 in order mem, fpu, vec on three consecutive cycles; final value C.
REQ-030 SHALL cover: fpu handshake at c0, rst_i high at c1 edge -> fpr_we_o=0, sb_clr_o=0 after c1; no write of the fpu data.
REQ-031 SHALL cover: no valids for 10 cycles after one write -> fpr_we_o low, fpr_waddr_o/fpr_wdata_o hold last values, grant_src_o=0.
REQ-032 SHALL cover: build without FPU_SS_VEC_WB_EN, mem and fpu valid c0-c9 -> alternating per REQ-015, grant_src_o in {0,1} only.

Source files
------------

// File: rtl/fpu_ss_fpr_wb_arbiter_if.sv
// Write-request bundle between the mem/fpu/vec result sources and the FP register-file write arbiter.
// The vec_* signals exist only when FPU_SS_VEC_WB_EN is defined.
interface fpu_ss_fpr_wb_arbiter_if #(
  parameter int unsigned FLEN = 32
);
  logic            mem_valid_i;
  logic            mem_ready_o;
  logic [4:0]      mem_addr_i;
  logic [FLEN-1:0] mem_data_i;

  logic            fpu_valid_i;
  logic            fpu_ready_o;
  logic [4:0]      fpu_addr_i;
  logic [FLEN-1:0] fpu_data_i;

`ifdef FPU_SS_VEC_WB_EN
  logic            vec_valid_i;
  logic            vec_ready_o;
  logic [4:0]      vec_addr_i;
  logic [FLEN-1:0] vec_data_i;
`endif

  logic            fpr_we_o;
  logic [4:0]      fpr_waddr_o;
  logic [FLEN-1:0] fpr_wdata_o;
  logic            sb_clr_o;
  logic [4:0]      sb_clr_addr_o;
  logic [1:0]      grant_src_o;

`ifdef FPU_SS_VEC_WB_EN
  modport slave (
    input  mem_valid_i, mem_addr_i, mem_data_i,
    input  fpu_valid_i, fpu_addr_i, fpu_data_i,
    input  vec_valid_i, vec_addr_i, vec_data_i,
    output mem_ready_o, fpu_ready_o, vec_ready_o,
    output fpr_we_o, fpr_waddr_o, fpr_wdata_o, sb_clr_o, sb_clr_addr_o, grant_src_o
  );
  modport master (
    output mem_valid_i, mem_addr_i, mem_data_i,
    output fpu_valid_i, fpu_addr_i, fpu_data_i,
    output vec_valid_i, vec_addr_i, vec_data_i,
    input  mem_ready_o, fpu_ready_o, vec_ready_o,
    input  fpr_we_o, fpr_waddr_o, fpr_wdata_o, sb_clr_o, sb_clr_addr_o, grant_src_o
  );
`else
  modport slave (
    input  mem_valid_i, mem_addr_i, mem_data_i,
    input  fpu_valid_i, fpu_addr_i, fpu_data_i,
    output mem_ready_o, fpu_ready_o,
    output fpr_we_o, fpr_waddr_o, fpr_wdata_o, sb_clr_o, sb_clr_addr_o, grant_src_o
  );
  modport master (
    output mem_valid_i, mem_addr_i, mem_data_i,
    output fpu_valid_i, fpu_addr_i, fpu_data_i,
    input  mem_ready_o, fpu_ready_o,
    input  fpr_we_o, fpr_waddr_o, fpr_wdata_o, sb_clr_o, sb_clr_addr_o, grant_src_o
  );
`endif
endinterface

// File: rtl/fpu_ss_fpr_wb_arbiter.sv
// FP register-file write-back arbiter: fixed priority mem > fpu (> vec) with starvation promotion.
// Define FPU_SS_VEC_WB_EN to add the vector-unit source and three-way arbitration.
module fpu_ss_fpr_wb_arbiter #(
  parameter int unsigned FLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  fpu_ss_fpr_wb_arbiter_if.slave        bus
);
`ifdef FPU_SS_VEC_WB_EN
  localparam int NSRC = 3;
`else
  localparam int NSRC = 2;
`endif
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NSRC-1:0] w_valid;
  logic [NSRC-1:0] w_prom;
  logic [NSRC-1:0] w_gnt;
  logic [4:0]      w_addr [NSRC];
  logic [FLEN-1:0] w_data [NSRC];
  logic [3:0]      r_starve [NSRC];

  logic            w_any;
  logic [1:0]      w_sel_src;
  logic [4:0]      w_sel_addr;
  logic [FLEN-1:0] w_sel_data;

  logic            r_we;
  logic [4:0]      r_waddr;
  logic [FLEN-1:0] r_wdata;
  logic [1:0]      r_src;

  // Index order doubles as fixed priority: 0 mem, 1 fpu, 2 vec.
  always_comb begin
    w_valid[0] = bus.mem_valid_i;
    w_addr[0]  = bus.mem_addr_i;
    w_data[0]  = bus.mem_data_i;
    w_valid[1] = bus.fpu_valid_i;
    w_addr[1]  = bus.fpu_addr_i;
    w_data[1]  = bus.fpu_data_i;
`ifdef FPU_SS_VEC_WB_EN
    w_valid[2] = bus.vec_valid_i;
    w_addr[2]  = bus.vec_addr_i;
    w_data[2]  = bus.vec_data_i;
`endif
  end

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_prom[i] = w_valid[i] && (r_starve[i] == LIMIT);
    end
  end

  // Promoted requesters outrank everyone else; within a class, lowest index wins.
  always_comb begin
    logic found;
    found      = 1'b0;
    w_gnt      = '0;
    w_sel_src  = 2'd0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && !rst_i && ((|w_prom) ? w_prom[i] : w_valid[i])) begin
        found      = 1'b1;
        w_gnt[i]   = 1'b1;
        w_sel_src  = 2'(i);
        w_sel_addr = w_addr[i];
        w_sel_data = w_data[i];
      end
    end
    w_any = found;
  end

  assign bus.mem_ready_o = w_gnt[0];
  assign bus.fpu_ready_o = w_gnt[1];
`ifdef FPU_SS_VEC_WB_EN
  assign bus.vec_ready_o = w_gnt[2];
`endif

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NSRC; i++) begin
      if (rst_i || !w_valid[i] || w_gnt[i]) begin
        r_starve[i] <= 4'd0;
      end else if (r_starve[i] != LIMIT) begin
        r_starve[i] <= r_starve[i] + 4'd1;
      end
    end
  end

  // Write port: address/data only move on a handshake so they hold across idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_src   <= 2'd0;
    end else begin
      r_we  <= w_any;
      r_src <= w_any ? w_sel_src : 2'd0;
      if (w_any) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign bus.fpr_we_o      = r_we;
  assign bus.fpr_waddr_o   = r_waddr;
  assign bus.fpr_wdata_o   = r_wdata;
  assign bus.sb_clr_o      = r_we;
  assign bus.sb_clr_addr_o = r_waddr;
  assign bus.grant_src_o   = r_src;
endmodule
